unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port, variable-latency unified memory between the core's instruction-fetch port and load/store port.
//  Sits between the riscv core (pc/instruction, alu_result/write_data/read_data/memwrite) and the memory.
//  Arbitrates, holds each access until the memory acks or times out, and returns the data. Drives a core stall.
// PARAMETERS
//  ADDR_W        64   address width, byte addresses
//  DATA_W        64   memory word width; fetch returns the 32-bit half selected by if_addr[2]
//  TIMEOUT       255  max cycles in BUSY waiting for mem_ack before error completion (1..65535)
//  D_STREAK_MAX  4    consecutive data grants allowed while a fetch is pending before fetch is forced
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-low reset
//  if_req     in   1       fetch request; held high until if_valid
//  if_addr    in   ADDR_W  fetch address (pc); bits [1:0] ignored
//  if_rdata   out  32      fetched instruction, valid when if_valid
//  if_valid   out  1       one-cycle completion pulse for fetch
//  d_req      in   1       load/store request; held high until d_valid
//  d_we       in   1       1 = store (memwrite), 0 = load
//  d_addr     in   ADDR_W  data address (alu_result); must be 8-byte aligned
//  d_wdata    in   DATA_W  store data (write_data)
//  d_rdata    out  DATA_W  load data, valid when d_valid
//  d_valid    out  1       one-cycle completion pulse for data
//  d_err      out  1       with d_valid: misaligned or timed out
//  if_err     out  1       with if_valid: timed out
//  stall      out  1       (if_req & ~if_valid) | (d_req & ~d_valid), combinational
//  mem_req    out  1       memory request, held until mem_ack or timeout
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  latched request address, [2:0] forced to 0
//  mem_wdata  out  DATA_W  latched store data
//  mem_rdata  in   DATA_W  memory read data, sampled when mem_ack
//  mem_ack    in   1       memory completion, one cycle
// BEHAVIOUR
//  Reset: state IDLE; all outputs except stall 0; streak and timeout counters 0. A reset mid-access drops mem_req at once; that access is abandoned with no valid pulse.
//  FSM: IDLE -> BUSY_IF | BUSY_D | RESP -> IDLE. Exactly one access is outstanding at any time.
//  IDLE: with d_req and d_addr[2:0]!=0 -> RESP with d_err=1 and no memory access.
//   Otherwise: if both requests are pending, data wins unless streak==D_STREAK_MAX, in which case fetch wins.
//   On a grant, latch the owner, address, we and wdata; mem_req=1 from the next cycle.
//  Streak: increments on a data grant while if_req=1; clears on any fetch grant or when if_req=0 in IDLE. Saturates at D_STREAK_MAX.
//  BUSY_*: mem_req/mem_we/mem_addr/mem_wdata stay stable.
//   On mem_ack: register the read data, go to RESP, mem_req=0 in RESP.
//   Timeout counter starts at 0 on entry and increments each cycle without ack. At TIMEOUT: go to RESP with the owner's err=1 and rdata=0.
//  RESP: the owner's valid=1 for exactly one cycle. if_rdata = if_addr[2] ? word[63:32] : word[31:0]. A store returns d_rdata=0. Then IDLE.
//   Requests are not sampled in RESP, so a req still high in the valid cycle is not re-granted.
//  Minimum latency is req high at cycle t, grant at t, mem_req at t+1, ack at t+1, valid at t+2. A misaligned access gives valid at t+1.
//  mem_ack outside BUSY is ignored. Request inputs changing after grant are ignored.
//  rdata outputs hold their last value between valid pulses.
// STRUCTURE
//  Shared header mem_arb_defs.v: state encodings (IDLE/BUSY_IF/BUSY_D/RESP) and owner encoding (OWN_IF/OWN_D).
//  Sub-module mem_arb_timer: loadable up-counter with clear, enable and terminal-count flag at TIMEOUT.
//  The FSM, streak counter and latches live in unified_mem_arbiter.
// TESTING
//  Fetch only: if_addr=0x104, mem acks after 3 cycles with 0xAAAA5555_12345678.
//   -> if_valid 1 cycle, if_rdata=0xAAAA5555, exactly 1 mem_req episode.
//  Simultaneous if_req and d_req load at 0x2000, ack after 1 cycle.
//   -> data is served first, fetch is granted in the IDLE after data's RESP, stall stays high throughout.
//  d_req held continuously with if_req pending, D_STREAK_MAX=4.
//   -> grant order D,D,D,D,IF,D; the streak counter resets after the fetch.
//  Store at 0x1003 -> d_valid with d_err=1 one cycle later, mem_req never asserted.
//  No mem_ack, TIMEOUT=8 -> mem_req high exactly 8 cycles, then if_valid with if_err=1 and if_rdata=0.
//  reset low while mem_req=1 -> mem_req=0 at once with no valid pulse; after release, a new fetch completes normally.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter: FSM states,
// access owner encoding, timer width and the fetch half-word selector.
package unified_mem_arbiter_pkg;

  localparam int TMR_W   = 16;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // A fetch returns the 32-bit instruction half picked by address bit 2.
  function automatic logic [INSTR_W-1:0] fetch_half(input logic [63:0] word,
                                                    input logic        hi);
    return hi ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Core-side (fetch + load/store) and memory-side buses of the arbiter.
// The arbiter is the slave of the core bus and the master of the memory bus.
interface core_mem_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_valid;
  logic              if_err;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_err;
  logic              stall;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_rdata, if_valid, if_err, d_rdata, d_valid, d_err, stall
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output if_rdata, if_valid, if_err, d_rdata, d_valid, d_err, stall
  );
endinterface

interface mem_bus_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/unified_mem_arbiter_timer.sv
// Loadable up-counter with clear and enable; o_tc flags the TIMEOUT-th
// counted cycle so the owner sees exactly TIMEOUT cycles of mem_req.
module unified_mem_arbiter_timer
  import unified_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] r_count;

  // NOTE: sequential state is assigned with <= only, so every reader in the
  // same edge sees the pre-edge value regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and load/store accesses onto one variable-latency memory,
// one access outstanding at a time, with timeout and core stall generation.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int TIMEOUT      = 255,
  parameter int D_STREAK_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  core_mem_if.slave  core,
  mem_bus_if.master  mem
);

  localparam int                  STREAK_W   = $clog2(D_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(D_STREAK_MAX);
  localparam logic [ADDR_W-1:0]   ALIGN_MASK = ~ADDR_W'(7);

  arb_state_e          r_state;
  owner_e              r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_mem_req;
  logic [STREAK_W-1:0] r_streak;
  logic                r_if_valid;
  logic                r_if_err;
  logic [INSTR_W-1:0]  r_if_rdata;
  logic                r_d_valid;
  logic                r_d_err;
  logic [DATA_W-1:0]   r_d_rdata;

  logic                w_busy;
  logic                w_misaligned;
  logic                w_grant_d;
  logic                w_grant_if;
  logic                w_tc;
  logic                w_done;
  logic [DATA_W-1:0]   w_word;

  assign w_busy       = (r_state == ST_BUSY_IF) || (r_state == ST_BUSY_D);
  assign w_misaligned = core.d_req && (core.d_addr[2:0] != 3'b000);
  // Data has priority until it has starved a pending fetch D_STREAK_MAX times.
  assign w_grant_d    = core.d_req && !w_misaligned &&
                        (!core.if_req || (r_streak != STREAK_CAP));
  assign w_grant_if   = core.if_req && !w_misaligned && !w_grant_d;
  assign w_done       = mem.mem_ack || w_tc;
  assign w_word       = mem.mem_ack ? mem.mem_rdata : '0;

  unified_mem_arbiter_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (!w_busy),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_busy && !mem.mem_ack),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_IF;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_mem_req  <= 1'b0;
      r_streak   <= '0;
      r_if_valid <= 1'b0;
      r_if_err   <= 1'b0;
      r_if_rdata <= '0;
      r_d_valid  <= 1'b0;
      r_d_err    <= 1'b0;
      r_d_rdata  <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_if_err   <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_err    <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (!core.if_req) r_streak <= '0;

          if (w_misaligned) begin
            r_owner   <= OWN_D;
            r_d_valid <= 1'b1;
            r_d_err   <= 1'b1;
            r_d_rdata <= '0;
            r_state   <= ST_RESP;
          end else if (w_grant_d) begin
            r_owner   <= OWN_D;
            r_addr    <= core.d_addr;
            r_we      <= core.d_we;
            r_wdata   <= core.d_wdata;
            r_mem_req <= 1'b1;
            r_state   <= ST_BUSY_D;
            if (core.if_req && (r_streak != STREAK_CAP)) r_streak <= r_streak + 1'b1;
          end else if (w_grant_if) begin
            r_owner   <= OWN_IF;
            r_addr    <= core.if_addr;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_mem_req <= 1'b1;
            r_state   <= ST_BUSY_IF;
            r_streak  <= '0;
          end
        end

        ST_BUSY_IF, ST_BUSY_D: begin
          if (w_done) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_RESP;
            if (r_owner == OWN_IF) begin
              r_if_valid <= 1'b1;
              r_if_err   <= !mem.mem_ack;
              r_if_rdata <= fetch_half(w_word, r_addr[2]);
            end else begin
              r_d_valid <= 1'b1;
              r_d_err   <= !mem.mem_ack;
              r_d_rdata <= r_we ? '0 : w_word;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr & ALIGN_MASK;
  assign mem.mem_wdata = r_wdata;

  assign core.if_valid = r_if_valid;
  assign core.if_err   = r_if_err;
  assign core.if_rdata = r_if_rdata;
  assign core.d_valid  = r_d_valid;
  assign core.d_err    = r_d_err;
  assign core.d_rdata  = r_d_rdata;
  // The core must stall in the very cycle it raises a request.
  assign core.stall    = (core.if_req & ~r_if_valid) | (core.d_req & ~r_d_valid);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed accesses push expected
// completions; a negedge monitor pops and compares on every valid pulse.
module tb_unified_mem_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int TMO  = 8;
  localparam int SMAX = 4;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  core_mem_if #(.ADDR_W(AW), .DATA_W(DW)) cif ();
  mem_bus_if  #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  unified_mem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .TIMEOUT      (TMO),
    .D_STREAK_MAX (SMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .core  (cif.slave),
    .mem   (mif.master)
  );

  typedef struct {
    bit          is_if;
    bit          err;
    logic [63:0] data;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic void expect_resp(input bit is_if, input bit err,
                                      input logic [63:0] data, input string tag);
    exp_t e;
    e.is_if = is_if;
    e.err   = err;
    e.data  = data;
    e.tag   = tag;
    sb_q.push_back(e);
  endfunction

  // ---------------- memory model ----------------
  logic [63:0] mem_arr [logic [63:0]];
  bit          mem_en;
  int          ack_delay;
  int          episodes;
  int          req_cycles;
  int          mm_cnt;
  bit          mm_prev;

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
  endfunction

  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mif.mem_ack = 1'b0;
      if (mif.mem_req === 1'b1) begin
        if (!mm_prev) begin
          episodes++;
          mm_cnt = 0;
        end
        mm_cnt++;
        req_cycles++;
        if (mem_en && mm_cnt == ack_delay) begin
          mif.mem_ack = 1'b1;
          if (mif.mem_we) begin
            mem_arr[mif.mem_addr] = mif.mem_wdata;
            mif.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
          end else begin
            mif.mem_rdata = mem_rd(mif.mem_addr);
          end
        end
      end
      mm_prev = (mif.mem_req === 1'b1);
    end
  end

  // ---------------- monitor ----------------
  task automatic mon_pop(input bit is_if, input logic [63:0] data, input logic err);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_valid: got a %s completion, required none",
               is_if ? "fetch" : "data");
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_owner"}, 64'(is_if), 64'(e.is_if));
      check({e.tag, "_err"},   64'(err),   64'(e.err));
      check({e.tag, "_rdata"}, data,       e.data);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cif.if_valid === 1'b1) mon_pop(1'b1, {32'h0, cif.if_rdata}, cif.if_err);
      if (cif.d_valid === 1'b1)  mon_pop(1'b0, cif.d_rdata, cif.d_err);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the already-raised requests until want_if/want_d completions arrive;
  // after a non-final completion the address steps and the request stays high.
  task automatic serve(input int want_if, input int want_d,
                       input logic [63:0] if_step, input logic [63:0] d_step,
                       output int if_lat, output int d_lat);
    int cyc       = 0;
    int if_seen   = 0;
    int d_seen    = 0;
    int stall_low = 0;
    if_lat = 0;
    d_lat  = 0;
    while ((if_seen < want_if || d_seen < want_d) && cyc < 200) begin
      tick();
      cyc++;
      if (cif.if_valid !== 1'b1 && cif.d_valid !== 1'b1 && cif.stall !== 1'b1) stall_low++;
      if (cif.d_valid === 1'b1) begin
        d_seen++;
        if (d_lat == 0) d_lat = cyc;
        if (d_seen >= want_d) cif.d_req = 1'b0;
        else cif.d_addr = cif.d_addr + d_step;
      end
      if (cif.if_valid === 1'b1) begin
        if_seen++;
        if (if_lat == 0) if_lat = cyc;
        if (if_seen >= want_if) cif.if_req = 1'b0;
        else cif.if_addr = cif.if_addr + if_step;
      end
    end
    check("serve_in_time", 64'(cyc < 200), 64'd1);
    check("stall_held", 64'(stall_low), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat_if;
    int          lat_d;
    int          ep0;
    int          rc0;
    logic [63:0] w;

    n_checks     = 0;
    n_errors     = 0;
    episodes     = 0;
    req_cycles   = 0;
    mm_cnt       = 0;
    mm_prev      = 1'b0;
    mem_en       = 1'b1;
    ack_delay    = 1;
    reset        = 1'b0;
    cif.if_req   = 1'b0;
    cif.if_addr  = '0;
    cif.d_req    = 1'b0;
    cif.d_we     = 1'b0;
    cif.d_addr   = '0;
    cif.d_wdata  = '0;

    // Reset state
    repeat (3) tick();
    check("rst_mem_req",  64'(mif.mem_req),  64'd0);
    check("rst_mem_we",   64'(mif.mem_we),   64'd0);
    check("rst_mem_addr", mif.mem_addr,      64'd0);
    check("rst_mem_wdata", mif.mem_wdata,    64'd0);
    check("rst_if_valid", 64'(cif.if_valid), 64'd0);
    check("rst_if_err",   64'(cif.if_err),   64'd0);
    check("rst_if_rdata", 64'(cif.if_rdata), 64'd0);
    check("rst_d_valid",  64'(cif.d_valid),  64'd0);
    check("rst_d_err",    64'(cif.d_err),    64'd0);
    check("rst_d_rdata",  cif.d_rdata,       64'd0);
    check("rst_stall",    64'(cif.stall),    64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Fetch only, ack in the third mem_req cycle, upper half selected
    mem_arr[64'h100] = 64'hAAAA5555_12345678;
    ack_delay = 3;
    ep0 = episodes;
    expect_resp(1'b1, 1'b0, 64'h0000_0000_AAAA_5555, "fetch_only");
    cif.if_addr = 64'h104;
    cif.if_req  = 1'b1;
    serve(1, 0, 64'd0, 64'd0, lat_if, lat_d);
    check("fetch_only_latency", 64'(lat_if), 64'd4);
    tick();
    check("fetch_only_episodes", 64'(episodes - ep0), 64'd1);
    check("fetch_only_pulse",    64'(cif.if_valid),   64'd0);
    check("fetch_only_hold",     64'(cif.if_rdata),   64'hAAAA_5555);

    // Simultaneous fetch and load: data first, fetch after data's RESP
    ack_delay = 1;
    w = mem_rd(64'h2000);
    expect_resp(1'b0, 1'b0, w, "simul_d");
    w = mem_rd(64'h208);
    expect_resp(1'b1, 1'b0, {32'h0, w[63:32]}, "simul_if");
    cif.if_addr = 64'h20C;
    cif.d_addr  = 64'h2000;
    cif.d_we    = 1'b0;
    cif.if_req  = 1'b1;
    cif.d_req   = 1'b1;
    serve(1, 1, 64'd0, 64'd0, lat_if, lat_d);
    check("simul_d_latency",  64'(lat_d),  64'd2);
    check("simul_if_latency", 64'(lat_if), 64'd5);
    tick();

    // Streak: D x4, IF, D x4, IF with both requests held
    for (int k = 0; k < 4; k++) begin
      w = mem_rd(64'h3000 + 64'(8 * k));
      expect_resp(1'b0, 1'b0, w, $sformatf("streak_d%0d", k));
    end
    w = mem_rd(64'h400);
    expect_resp(1'b1, 1'b0, {32'h0, w[31:0]}, "streak_if0");
    for (int k = 4; k < 8; k++) begin
      w = mem_rd(64'h3000 + 64'(8 * k));
      expect_resp(1'b0, 1'b0, w, $sformatf("streak_d%0d", k));
    end
    expect_resp(1'b1, 1'b0, {32'h0, w[63:32]}, "streak_if1_placeholder");
    void'(sb_q.pop_back());
    w = mem_rd(64'h400);
    expect_resp(1'b1, 1'b0, {32'h0, w[63:32]}, "streak_if1");
    cif.if_addr = 64'h400;
    cif.d_addr  = 64'h3000;
    cif.if_req  = 1'b1;
    cif.d_req   = 1'b1;
    serve(2, 8, 64'd4, 64'd8, lat_if, lat_d);
    tick();

    // Misaligned store: error after one cycle, no memory access
    ep0 = episodes;
    expect_resp(1'b0, 1'b1, 64'd0, "misaligned");
    cif.d_addr  = 64'h1003;
    cif.d_we    = 1'b1;
    cif.d_wdata = 64'h1111_2222_3333_4444;
    cif.d_req   = 1'b1;
    serve(0, 1, 64'd0, 64'd0, lat_if, lat_d);
    check("misaligned_latency", 64'(lat_d), 64'd1);
    tick();
    check("misaligned_no_mem", 64'(episodes - ep0), 64'd0);

    // Aligned store then load back
    ack_delay = 2;
    expect_resp(1'b0, 1'b0, 64'd0, "store");
    cif.d_addr  = 64'h1008;
    cif.d_we    = 1'b1;
    cif.d_wdata = 64'h0123_4567_89AB_CDEF;
    cif.d_req   = 1'b1;
    serve(0, 1, 64'd0, 64'd0, lat_if, lat_d);
    check("store_latency", 64'(lat_d), 64'd3);
    check("store_written", mem_rd(64'h1008), 64'h0123_4567_89AB_CDEF);
    tick();
    expect_resp(1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, "load_back");
    cif.d_we  = 1'b0;
    cif.d_req = 1'b1;
    serve(0, 1, 64'd0, 64'd0, lat_if, lat_d);
    tick();

    // Timeout: no ack, mem_req high exactly TIMEOUT cycles
    mem_en = 1'b0;
    rc0 = req_cycles;
    expect_resp(1'b1, 1'b1, 64'd0, "timeout");
    cif.if_addr = 64'h500;
    cif.if_req  = 1'b1;
    serve(1, 0, 64'd0, 64'd0, lat_if, lat_d);
    check("timeout_latency",   64'(lat_if), 64'd9);
    tick();
    check("timeout_req_cycles", 64'(req_cycles - rc0), 64'd8);
    mem_en = 1'b1;

    // Reset during an outstanding access
    mem_en      = 1'b0;
    cif.if_addr = 64'h600;
    cif.if_req  = 1'b1;
    for (int i = 0; i < 20 && mif.mem_req !== 1'b1; i++) tick();
    check("rst_mid_req_seen", 64'(mif.mem_req), 64'd1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_req_drop", 64'(mif.mem_req), 64'd0);
    cif.if_req = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    reset  = 1'b1;
    mem_en = 1'b1;
    ack_delay = 1;
    repeat (3) tick();
    w = mem_rd(64'h600);
    expect_resp(1'b1, 1'b0, {32'h0, w[63:32]}, "post_reset_fetch");
    cif.if_addr = 64'h604;
    cif.if_req  = 1'b1;
    serve(1, 0, 64'd0, 64'd0, lat_if, lat_d);
    check("post_reset_latency", 64'(lat_if), 64'd2);

    repeat (4) tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("stall_idle", 64'(cif.stall),   64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
